morse_playback_ctrl: RTL and testbench

//  Upstream controller for the 12-bit Morse rotating register (element LSB-out, Q[0] drives LED).

---
 rtl/morse_pkg.sv | 55 +++++
 rtl/morse_rate_divider.sv | 42 ++++
 rtl/morse_playback_ctrl.sv | 138 +++++++++++++
 tb/tb_morse_playback_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and letter tables for the Morse playback controller.
// Patterns are LSB-first: bit0 is the first element shown on the LED.
package morse_pkg;

  localparam int MORSE_PATTERN_W = 12;
  localparam int MORSE_LEN_W     = 4;
  localparam int MORSE_LETTERS   = 8;
  localparam int MORSE_GAP_TICKS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_e;

  typedef logic [2:0] letter_t;

  // dot = 1, dash = 111, intra-letter gap = 0
  localparam logic [MORSE_PATTERN_W-1:0] MORSE_PATTERN [0:MORSE_LETTERS-1] = '{
    12'h01D,
    12'h157,
    12'h5D7,
    12'h057,
    12'h001,
    12'h175,
    12'h177,
    12'h055
  };

  localparam logic [MORSE_LEN_W-1:0] MORSE_LEN [0:MORSE_LETTERS-1] = '{
    4'd5,
    4'd9,
    4'd11,
    4'd7,
    4'd1,
    4'd9,
    4'd9,
    4'd7
  };

  function automatic logic [MORSE_PATTERN_W-1:0] morse_pattern(
    input letter_t l
  );
    return MORSE_PATTERN[l];
  endfunction

  function automatic logic [MORSE_LEN_W-1:0] morse_len(
    input letter_t l
  );
    return MORSE_LEN[l];
  endfunction

endpackage

// File: rtl/morse_rate_divider.sv
// Element-rate divider: counts 0..CLK_DIV-1 while enabled.
// tick marks the last count of each element period.
module morse_rate_divider #(
  parameter int CLK_DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/morse_playback_ctrl.sv
// Morse playback controller feeding a 12-bit LSB-out rotating register.
// Define MORSE_LETTER_GAP_EN to add a dark inter-letter gap before done.
module morse_playback_ctrl
  import morse_pkg::*;
#(
  parameter int CLK_DIV   = 25_000_000,
  parameter int PATTERN_W = MORSE_PATTERN_W,
  parameter int LEN_W     = MORSE_LEN_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           letter_sel,
  output logic [PATTERN_W-1:0] pattern,
  output logic                 load_n,
  output logic                 shift_en,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q;
  state_e               state_d;
  logic [PATTERN_W-1:0] pattern_q;
  logic [PATTERN_W-1:0] pattern_d;
  logic [LEN_W-1:0]     count_q;
  logic [LEN_W-1:0]     count_d;
  logic                 load_n_q;
  logic                 load_n_d;
  logic                 shift_en_q;
  logic                 shift_en_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 done_q;
  logic                 done_d;

  logic div_clr;
  logic div_en;
  logic tick;

  morse_rate_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .clr   (div_clr),
    .en    (div_en),
    .tick  (tick)
  );

  // count reaches zero on the last tick; the exit happens one cycle
  // later so done never coincides with the final shift.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    count_d    = count_q;
    shift_en_d = 1'b0;
    div_clr    = 1'b0;
    div_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_clr = 1'b1;
        if (start) begin
          state_d   = LOAD;
          pattern_d = PATTERN_W'(morse_pattern(letter_t'(letter_sel)));
          count_d   = LEN_W'(morse_len(letter_t'(letter_sel)));
        end
      end
      LOAD: begin
        div_en  = 1'b1;
        state_d = PLAY;
      end
      PLAY: begin
        div_en = 1'b1;
        if (tick) begin
          shift_en_d = 1'b1;
          count_d    = count_q - LEN_W'(1);
        end else if (count_q == '0) begin
`ifdef MORSE_LETTER_GAP_EN
          state_d = GAP;
          count_d = LEN_W'(MORSE_GAP_TICKS);
`else
          state_d = DONE;
`endif
        end
      end
      GAP: begin
        div_en = 1'b1;
        if (tick) begin
          count_d = count_q - LEN_W'(1);
        end else if (count_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        div_clr = 1'b1;
        state_d = IDLE;
      end
      default: begin
        div_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_comb begin
    load_n_d = (state_d != LOAD);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pattern_q  <= '0;
      count_q    <= '0;
      load_n_q   <= 1'b1;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      count_q    <= count_d;
      load_n_q   <= load_n_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pattern  = pattern_q;
  assign load_n   = load_n_q;
  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_morse_playback_ctrl.sv
// Bench for morse_playback_ctrl with CLK_DIV=4.
// Honours MORSE_LETTER_GAP_EN for the expected done latency.
module tb_morse_playback_ctrl;

`ifdef MORSE_LETTER_GAP_EN
  localparam int GAP_X = 12;
`else
  localparam int GAP_X = 0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  letter_sel;
  logic [11:0] pattern;
  logic        load_n;
  logic        shift_en;
  logic        busy;
  logic        done;

  morse_playback_ctrl #(
    .CLK_DIV   (4),
    .PATTERN_W (12),
    .LEN_W     (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .letter_sel (letter_sel),
    .pattern    (pattern),
    .load_n     (load_n),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  letter;
    logic [11:0] pat;
    int          len;
    bit          hammer;
    bit          change;
  } vec_t;

  typedef struct {
    logic [11:0] pat;
    int          len;
    int          busy_n;
    int          lat;
  } exp_t;

  typedef struct {
    logic [11:0] pat;
    int          pulses;
    int          gap_bad;
    logic [11:0] led;
    int          lat;
    int          busy_n;
    logic [11:0] pat_end;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  obs_t cur;
  int   overlap = 0;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, int act, int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endfunction

  // Monitor: builds an observation per playback, modelling the
  // rotating register so the LED (Q[0]) sequence can be checked.
  initial begin
    logic [11:0] m_reg;
    int          last;
    m_reg = '0;
    last  = 0;
    cur   = '{default: 0};
    forever begin
      @(negedge clock);
      if (!reset) continue;
      if (!load_n) begin
        cur        = '{default: 0};
        cur.pat    = pattern;
        m_reg      = pattern;
        cur.led[0] = pattern[0];
        last       = cyc;
      end
      if (busy) cur.busy_n++;
      if (shift_en) begin
        if (cyc - last != 4) cur.gap_bad++;
        last = cyc;
        cur.pulses++;
        m_reg = {m_reg[0], m_reg[11:1]};
        if (cur.pulses < 12) cur.led[cur.pulses] = m_reg[0];
      end
      if (!load_n && shift_en) overlap++;
      if (done) begin
        cur.lat     = cyc - last;
        cur.pat_end = pattern;
        obs_q.push_back(cur);
      end
    end
  end

  task automatic play(input vec_t v);
    exp_t e;
    obs_t o;
    bit   got;
    e.pat    = v.pat;
    e.len    = v.len;
    e.busy_n = v.len * 4 + 2 + GAP_X;
    e.lat    = 1 + GAP_X;
    exp_q.push_back(e);
    @(negedge clock);
    letter_sel = v.letter;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      #2;
      if (v.hammer) start = (i % 3 == 0) || done;
      if (v.change && i == 10) letter_sel = v.letter ^ 3'd5;
      if (obs_q.size() > 0) got = 1'b1;
    end
    if (v.hammer) begin
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL timeout letter %0d: got no done expected done", v.letter);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("pattern_l%0d", v.letter), int'(o.pat), int'(e.pat));
      chk($sformatf("pulses_l%0d", v.letter), o.pulses, e.len);
      chk($sformatf("spacing_l%0d", v.letter), o.gap_bad, 0);
      chk($sformatf("led_seq_l%0d", v.letter), int'(o.led), int'(e.pat));
      chk($sformatf("done_lat_l%0d", v.letter), o.lat, e.lat);
      chk($sformatf("busy_len_l%0d", v.letter), o.busy_n, e.busy_n);
      chk($sformatf("pat_hold_l%0d", v.letter), int'(o.pat_end), int'(e.pat));
    end
    repeat (6) @(negedge clock);
    #2;
    chk($sformatf("no_extra_done_l%0d", v.letter), obs_q.size(), 0);
    chk($sformatf("idle_after_l%0d", v.letter), int'(busy), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'd2, 12'h5D7, 11, 1'b0, 1'b0};
    vecs[1] = '{3'd0, 12'h01D, 5,  1'b0, 1'b0};
    vecs[2] = '{3'd4, 12'h001, 1,  1'b0, 1'b0};
    vecs[3] = '{3'd1, 12'h157, 9,  1'b1, 1'b0};
    vecs[4] = '{3'd3, 12'h057, 7,  1'b0, 1'b1};
    vecs[5] = '{3'd5, 12'h175, 9,  1'b0, 1'b0};
    vecs[6] = '{3'd6, 12'h177, 9,  1'b0, 1'b0};
    vecs[7] = '{3'd7, 12'h055, 7,  1'b0, 1'b0};

    reset      = 1'b0;
    start      = 1'b0;
    letter_sel = 3'd0;
    repeat (3) @(negedge clock);
    chk("rst_pattern", int'(pattern), 0);
    chk("rst_load_n", int'(load_n), 1);
    chk("rst_shift_en", int'(shift_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b1;

    // Reset mid-PLAY of C
    @(negedge clock);
    letter_sel = 3'd2;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    chk("busy_before_reset", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_pattern", int'(pattern), 0);
    chk("midrst_load_n", int'(load_n), 1);
    chk("midrst_shift_en", int'(shift_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    chk("no_done_after_reset", obs_q.size(), 0);

    for (int k = 0; k < 8; k++) play(vecs[k]);

    chk("load_shift_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
